// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide)
// Ports: clk, rst (sync, active-high); in_valid/in_ready with op (funct3), a, b;
//        out_valid/out_ready with result.
// Build option MDU_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero-operand
// multiplies skip CALC and complete one cycle after accept (same result values).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] p_q;
    logic               neg_q, negr_q, in_ready_q, out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               sa, sb, na, nb, b_zero, ge;
    logic [WIDTH-1:0]   a_mag, b_mag, q, r, res_d;
    logic [WIDTH:0]     sum, t;
    logic [2*WIDTH-1:0] p_d, prod;
    assign sa     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign sb     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign na     = sa & a[WIDTH-1];
    assign nb     = sb & b[WIDTH-1];
    assign a_mag  = na ? -a : a;
    assign b_mag  = nb ? -b : b;
    assign b_zero = b == '0;
`ifdef MDU_FAST_SPECIAL_EN
    logic             fast;
    logic [WIDTH-1:0] fast_res;
    // Overflow result equals a (min_signed), so a doubles as the DIV value there.
    assign fast     = op[2] ? (b_zero || (!op[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && &b))
                            : (a == '0 || b_zero);
    assign fast_res = op[2] ? (b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a)) : '0;
`endif
    // p_q holds {high, low} product during multiply and {remainder, dividend/quotient} during divide.
    always_comb begin
        sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        t     = p_q[2*WIDTH-1:WIDTH-1];
        ge    = t >= {1'b0, m_q};
        p_d   = op_q[2] ? (ge ? {t[WIDTH-1:0] - m_q, p_q[WIDTH-2:0], 1'b1}
                              : {t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0})
                        : {sum, p_q[WIDTH-1:1]};
        prod  = neg_q ? -p_d : p_d;
        q     = neg_q ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
        r     = negr_q ? -p_d[2*WIDTH-1:WIDTH] : p_d[2*WIDTH-1:WIDTH];
        res_d = op_q[2] ? (op_q[1] ? r : q)
                        : (op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            m_q         <= '0;
            p_q         <= '0;
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    op_q       <= op;
                    m_q        <= b_mag;
                    p_q        <= {{WIDTH{1'b0}}, a_mag};
                    // A zero divisor must yield an all-ones quotient, so no negation then.
                    neg_q      <= (na ^ nb) & ~(op[2] & b_zero);
                    negr_q     <= na;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
`ifdef MDU_FAST_SPECIAL_EN
                    if (fast) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fast_res;
                    end else begin
                        state_q <= CALC;
                    end
`else
                    state_q    <= CALC;
`endif
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    p_q   <= p_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= res_d;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors plus backpressure, busy-ignore and reset sequences
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    int n_chk = 0;
    int n_fail = 0;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sp;
    } vec_t;
    vec_t v[20];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Issue one request, scramble inputs after accept, wait for the result.
    // lat counts cycles: the accept cycle is T, lat is the cycle number after T with out_valid=1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = result;
    endtask
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
    logic [31:0] res, r0;
    int lat;
    initial begin
        v[0]  = '{"mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        v[1]  = '{"mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        v[2]  = '{"mulhu_8_8",     3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        v[3]  = '{"mulhsu_m1_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        v[4]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        v[5]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        v[6]  = '{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
        v[7]  = '{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
        v[8]  = '{"div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        v[9]  = '{"rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,        1'b1};
        v[10] = '{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        v[11] = '{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        v[12] = '{"mul_zero",      3'b000, 32'd0,        32'd12345,    32'd0,        1'b1};
        v[13] = '{"mulhu_max_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        v[14] = '{"divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        v[15] = '{"remu_big_0",    3'b111, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1};
        v[16] = '{"div_m7_0",      3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1};
        v[17] = '{"rem_7_m2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
        v[18] = '{"div_7_m2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        v[19] = '{"mulh_min_max",  3'b001, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 1'b0};
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk({v[i].name, "_ready"}, {31'd0, in_ready}, 32'd1);
            issue(v[i].op, v[i].a, v[i].b, res, lat);
            chk(v[i].name, res, v[i].exp);
            chk({v[i].name, "_lat"}, lat, (FAST && v[i].sp) ? 32'd1 : 32'd33);
            drain();
        end
        // Busy-ignore and backpressure on a MUL 3*5.
        op = 3'b000;
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        op = 3'b101;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 4;
        while (!out_valid && lat < 100) begin
            chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        chk("bp_lat", lat, 32'd33);
        chk("bp_result", result, 32'd15);
        r0 = result;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_result", result, r0);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();
        chk("exit_in_ready", {31'd0, in_ready}, 32'd1);
        chk("exit_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("no_ghost_valid", {31'd0, out_valid}, 32'd0);
        // Reset during CALC cycle 10.
        op = 3'b101;
        a = 32'd1000;
        b = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        issue(3'b101, 32'd9, 32'd3, res, lat);
        chk("post_rst_divu", res, 32'd3);
        chk("post_rst_lat", lat, 32'd33);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
